// File: rtl/seq_multiplier_16bit.sv
// Unsigned 16x16 shift-and-add multiplier producing a 32-bit product in 16 RUN cycles,
// built around a single 16-bit lookahead-carry adder.

module CLA_16bit_withLCU (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Cin,
   output logic [15:0] S,
   output logic        C,
   output logic        P,
   output logic        G
);
   logic [15:0] p;
   logic [15:0] g;
   logic [15:0] cb;
   logic [3:0]  gp;
   logic [3:0]  gg;
   logic [3:0]  gc;

   assign p = A ^ B;
   assign g = A & B;

   // Lookahead carry unit: group carries straight from group propagate/generate
   assign gc[0] = Cin;
   assign gc[1] = gg[0] | (gp[0] & Cin);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & Cin);

   assign P = &gp;
   assign G = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0]);
   assign C = G | (P & Cin);

   for (genvar i = 0; i < 4; i++) begin : g_grp
      localparam int L = 4 * i;
      assign gp[i] = p[L+3] & p[L+2] & p[L+1] & p[L];
      assign gg[i] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                   | (p[L+3] & p[L+2] & p[L+1] & g[L]);
      assign cb[L]   = gc[i];
      assign cb[L+1] = g[L] | (p[L] & gc[i]);
      assign cb[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & gc[i]);
      assign cb[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                     | (p[L+2] & p[L+1] & p[L] & gc[i]);
   end

   assign S = p ^ cb;
endmodule

module seq_multiplier_16bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] m;
   logic [15:0] acc;
   logic        cy;
   logic [15:0] q;
   logic [4:0]  cnt;

   logic [15:0] sum;
   logic        sum_c;
   logic        unused_p;
   logic        unused_g;
   logic [15:0] acc_add;
   logic        cy_add;
   logic [15:0] acc_sh;
   logic [15:0] q_sh;

   CLA_16bit_withLCU u_cla (
      .A   (acc),
      .B   (m),
      .Cin (1'b0),
      .S   (sum),
      .C   (sum_c),
      .P   (unused_p),
      .G   (unused_g)
   );

   // cy is always 0 between RUN steps, so the no-add path is {0, acc}
   always_comb begin
      cy_add  = cy;
      acc_add = acc;
      if (q[0]) begin
         cy_add  = sum_c;
         acc_add = sum;
      end
      acc_sh = {cy_add, acc_add[15:1]};
      q_sh   = {acc_add[0], q[15:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == 5'd15) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m       <= '0;
         acc     <= '0;
         cy      <= 1'b0;
         q       <= '0;
         cnt     <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  m   <= a;
                  q   <= b;
                  acc <= '0;
                  cy  <= 1'b0;
                  cnt <= '0;
               end
            end
            RUN: begin
               acc <= acc_sh;
               q   <= q_sh;
               cy  <= 1'b0;
               cnt <= cnt + 5'd1;
               // Final step: capture the shifted result as DONE is entered
               if (cnt == 5'd15) product <= {acc_sh, q_sh};
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_multiplier_16bit.sv
// Directed-vector bench for seq_multiplier_16bit: latency, busy window, product values,
// start-ignored-while-busy, mid-run reset abort and back-to-back throughput.

module tb_seq_multiplier_16bit;
   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int n_cmp;
   int n_err;
   int done_pulses;

   seq_multiplier_16bit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_pulses++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Start one multiply, scramble a/b during the run, and check latency, busy and product
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp);
      int lat;
      int busy_n;
      bit seen;
      a = av;
      b = bv;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      lat = 0;
      busy_n = busy ? 1 : 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         tick(1);
         lat++;
         if (done) seen = 1'b1;
         else if (busy) busy_n++;
      end
      check_val({tag, "_lat"}, 32'(lat), 32'd17);
      check_val({tag, "_busy"}, 32'(busy_n), 32'd17);
      check_val({tag, "_prod"}, product, exp);
      tick(1);
      check_val({tag, "_done_width"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int base;
      int cyc;
      int d_idx [4];
      int nd;
      n_cmp = 0;
      n_err = 0;
      done_pulses = 0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      tick(3);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_prod", product, 32'd0);
      rst = 1'b0;
      tick(2);

      run_op("mul_3x5", 16'd3, 16'd5, 32'h0000_000F);
      run_op("mul_ffff_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      run_op("mul_b0", 16'h1234, 16'h0000, 32'h0000_0000);
      run_op("mul_a0", 16'h0000, 16'hBEEF, 32'h0000_0000);
      run_op("mul_8000x2", 16'h8000, 16'h0002, 32'h0001_0000);
      run_op("mul_ab_cd", 16'hABCD, 16'h1234, 32'h0C37_4FA4);

      // Product holds through idle cycles
      tick(5);
      check_val("hold_idle", product, 32'h0C37_4FA4);

      // start pulsed mid-RUN is ignored
      base = done_pulses;
      a = 16'd7;
      b = 16'd9;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(5);
      a = 16'd1;
      b = 16'd1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin
         tick(1);
         cyc++;
      end
      check_val("ign_prod", product, 32'h0000_003F);
      tick(25);
      check_val("ign_pulses", 32'(done_pulses - base), 32'd1);
      check_val("ign_hold", product, 32'h0000_003F);
      check_val("ign_idle", {31'd0, busy}, 32'd0);

      // Reset at RUN cycle 8 aborts with no done pulse
      base = done_pulses;
      a = 16'h1234;
      b = 16'h5678;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(8);
      rst = 1'b1;
      tick(1);
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_done", {31'd0, done}, 32'd0);
      check_val("abort_prod", product, 32'd0);
      rst = 1'b0;
      tick(20);
      check_val("abort_pulses", 32'(done_pulses - base), 32'd0);
      run_op("mul_100x200", 16'd100, 16'd200, 32'h0000_4E20);

      // Reset wins over start on the same edge
      rst = 1'b1;
      start = 1'b1;
      tick(1);
      check_val("rst_prio_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      start = 1'b0;
      tick(2);

      // start held high: one result every 18 cycles
      a = 16'hFFFF;
      b = 16'h0002;
      start = 1'b1;
      nd = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (done) begin
            if (nd < 4) d_idx[nd] = i;
            nd++;
            check_val("b2b_prod", product, 32'h0001_FFFE);
         end
      end
      start = 1'b0;
      check_val("b2b_count", 32'(nd), 32'd3);
      if (nd >= 3) begin
         check_val("b2b_gap1", 32'(d_idx[1] - d_idx[0]), 32'd18);
         check_val("b2b_gap2", 32'(d_idx[2] - d_idx[1]), 32'd18);
      end
      cyc = 0;
      while ((busy || done) && cyc < 40) begin
         tick(1);
         cyc++;
      end
      check_val("b2b_drain", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
